// File: rtl/paro_rampa_parcial.sv
// paro_rampa_parcial: soft-stop (ramp-down) motor controller.
// In RUN it follows the speed level coming from the start FSM. On a stop request
// it steps the duty down 100 -> 50 -> 30 -> 0 % with a selectable dwell per step,
// drives a 100-slot PWM and mirrors the active level on one-hot lamps.
// Optional macro PARO_EMERGENCY_STOP_EN adds the estop_n input (active-low,
// two-flop synchronised) that forces STOPPED immediately, bypassing the ramp.
module paro_rampa_parcial #(
    parameter int TICK_DIV   = 1000,
    parameter int DWELL_FAST = 2,
    parameter int DWELL_SLOW = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] lvl_in,
    input  logic       stop_req,
    input  logic       rapido,
    input  logic       lento,
`ifdef PARO_EMERGENCY_STOP_EN
    input  logic       estop_n,
`endif
    output logic       pwm_out,
    output logic       out_30,
    output logic       out_50,
    output logic       out_100,
    output logic       busy,
    output logic       stopped
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_DN100   = 3'd2;
    localparam logic [2:0] ST_DN50    = 3'd3;
    localparam logic [2:0] ST_DN30    = 3'd4;
    localparam logic [2:0] ST_STOPPED = 3'd5;

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DMAX = (DWELL_FAST > DWELL_SLOW) ? DWELL_FAST : DWELL_SLOW;
    localparam int DW   = $clog2(DMAX + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    DUTY_0     = 7'd0;
    localparam logic [6:0]    DUTY_30    = 7'd30;
    localparam logic [6:0]    DUTY_50    = 7'd50;
    localparam logic [6:0]    DUTY_100   = 7'd100;
    localparam logic [6:0]    CNT_LAST   = 7'd99;

    logic [2:0]    state;
    logic [2:0]    state_n;
    logic [6:0]    duty;
    logic [6:0]    duty_n;
    logic [6:0]    lvl_dec;
    logic [6:0]    cnt;
    logic [PW-1:0] presc;
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_sel;
    logic          tick;
    logic          step_done;
    logic          entering;
    logic          is_ramp_n;
    logic          est_ok;

`ifdef PARO_EMERGENCY_STOP_EN
    logic est_s1;
    logic est_s2;

    // Two-flop synchroniser for the asynchronous emergency-stop input (idle high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            est_s1 <= 1'b1;
            est_s2 <= 1'b1;
        end else if (ena) begin
            est_s1 <= estop_n;
            est_s2 <= est_s1;
        end
    end

    assign est_ok = est_s2;
`else
    assign est_ok = 1'b1;
`endif

    // Priority decode of the start-FSM level: the highest set bit wins
    always_comb begin
        if (lvl_in[2])      lvl_dec = DUTY_100;
        else if (lvl_in[1]) lvl_dec = DUTY_50;
        else if (lvl_in[0]) lvl_dec = DUTY_30;
        else                lvl_dec = DUTY_0;
    end

    assign tick      = (presc == PRESC_LAST);
    // The last tick of a step is the one that takes the dwell count from 1 to 0
    assign step_done = tick && (dwell == DW'(1));
    assign dwell_sel = (rapido && !lento) ? DW'(DWELL_FAST) : DW'(DWELL_SLOW);
    assign entering  = (state_n != state);
    assign is_ramp_n = (state_n == ST_DN100) || (state_n == ST_DN50) || (state_n == ST_DN30);

    // Next-state and next-duty logic; duty always matches the state it lands in
    always_comb begin
        state_n = state;
        duty_n  = duty;
        case (state)
            ST_IDLE: begin
                duty_n = DUTY_0;
                if (!stop_req && (lvl_dec != DUTY_0)) begin
                    state_n = ST_RUN;
                    duty_n  = lvl_dec;
                end
            end
            ST_RUN: begin
                if (stop_req) begin
                    duty_n = lvl_dec;
                    if (lvl_dec == DUTY_100)     state_n = ST_DN100;
                    else if (lvl_dec == DUTY_50) state_n = ST_DN50;
                    else if (lvl_dec == DUTY_30) state_n = ST_DN30;
                    else                         state_n = ST_STOPPED;
                end else if (lvl_dec == DUTY_0) begin
                    state_n = ST_IDLE;
                    duty_n  = DUTY_0;
                end else begin
                    duty_n = lvl_dec;
                end
            end
            ST_DN100: begin
                if (step_done) begin
                    state_n = ST_DN50;
                    duty_n  = DUTY_50;
                end
            end
            ST_DN50: begin
                if (step_done) begin
                    state_n = ST_DN30;
                    duty_n  = DUTY_30;
                end
            end
            ST_DN30: begin
                if (step_done) begin
                    state_n = ST_STOPPED;
                    duty_n  = DUTY_0;
                end
            end
            ST_STOPPED: begin
                duty_n = DUTY_0;
                if (!stop_req && est_ok) state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                duty_n  = DUTY_0;
            end
        endcase
        // Emergency stop overrides everything, including an in-progress ramp
        if (!est_ok) begin
            state_n = ST_STOPPED;
            duty_n  = DUTY_0;
        end
    end

    // State and duty registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            duty  <= DUTY_0;
        end else if (ena) begin
            state <= state_n;
            duty  <= duty_n;
        end
    end

    // Prescaler restarts on every state entry so each step lasts exactly D*TICK_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            dwell <= '0;
        end else if (ena) begin
            if (entering || tick) presc <= '0;
            else                  presc <= presc + 1'b1;
            if (entering)                    dwell <= is_ramp_n ? dwell_sel : '0;
            else if (tick && (dwell != '0))  dwell <= dwell - 1'b1;
        end
    end

    // Free-running PWM slot counter and registered compare output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pwm_out <= 1'b0;
        end else if (ena) begin
            cnt     <= (cnt == CNT_LAST) ? 7'd0 : cnt + 7'd1;
            pwm_out <= est_ok && (cnt < duty);
        end
    end

    assign out_30  = (duty == DUTY_30);
    assign out_50  = (duty == DUTY_50);
    assign out_100 = (duty == DUTY_100);
    assign busy    = (state == ST_DN100) || (state == ST_DN50) || (state == ST_DN30);
    assign stopped = (state == ST_IDLE) || (state == ST_STOPPED);

endmodule
